// File: rtl/sti_so_packer.sv
// Receives STI_DAC serial bursts, packs them MSB-first into bytes with a last-of-burst flag,
// and queues them in a first-word fall-through FIFO behind a valid/ready interface.
//
// state | meaning
// IDLE  | no burst in progress
// RECV  | burst bits arriving
// FLUSH | padded partial tail byte is pushed this cycle
module sti_so_packer #(
    parameter int   FIFO_DEPTH = 4,
    parameter logic PAD_BIT    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       so_data,
    input  logic       so_valid,
    output logic [7:0] byte_data,
    output logic [3:0] byte_nbits,
    output logic       byte_last,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       overflow,
    output logic [7:0] burst_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

    state_t      state_q, state_d;
    logic        so_valid_d;
    logic [7:0]  sh;
    logic [2:0]  cnt;
    logic [7:0]  hold;
    logic        hold_v;
    logic [7:0]  tail;
    logic [3:0]  tail_n;
    logic [7:0]  tail_next;
    logic [2:0]  tail_shamt;

    logic        burst_end;
    logic        hold_push;
    logic        tail_push;
    logic        push;
    logic [12:0] push_ent;

    logic [12:0] mem [FIFO_DEPTH];
    logic [12:0] head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, pop, wr_en;

    assign burst_end = so_valid_d & ~so_valid;
    assign hold_push = hold_v & (so_valid | burst_end);

    // Remaining cnt bits sit in the low end of sh; shift them to the top and fill below.
    always_comb begin
        tail_shamt = 3'd0 - cnt;
        tail_next  = (sh << tail_shamt) | ({8{PAD_BIT}} & (8'hFF >> cnt));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tail_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (so_valid) state_d = RECV;
            end
            RECV: begin
                if (burst_end) state_d = (cnt != 3'd0) ? FLUSH : IDLE;
            end
            FLUSH: begin
                tail_push = 1'b1;
                state_d   = so_valid ? RECV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pending tail and a pending hold byte never coincide, so the order here is arbitrary.
    always_comb begin
        push     = 1'b0;
        push_ent = '0;
        if (tail_push) begin
            push     = 1'b1;
            push_ent = {tail, tail_n, 1'b1};
        end else if (hold_push) begin
            push     = 1'b1;
            push_ent = {hold, 4'd8, burst_end & (cnt == 3'd0)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            so_valid_d <= 1'b0;
            sh         <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_v     <= 1'b0;
            tail       <= '0;
            tail_n     <= '0;
            burst_cnt  <= '0;
        end else begin
            so_valid_d <= so_valid;
            if (hold_push) hold_v <= 1'b0;
            if (so_valid) begin
                sh  <= {sh[6:0], so_data};
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    hold   <= {sh[6:0], so_data};
                    hold_v <= 1'b1;
                end
            end else if (burst_end) begin
                burst_cnt <= burst_cnt + 8'd1;
                if (cnt != 3'd0) begin
                    tail   <= tail_next;
                    tail_n <= {1'b0, cnt};
                    cnt    <= 3'd0;
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = ~fifo_empty & byte_ready;
    // When full, a simultaneous pop frees the slot being written.
    assign wr_en      = push & (~fifo_full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (push & fifo_full & ~pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ent;
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign byte_valid = ~fifo_empty;
    assign {byte_data, byte_nbits, byte_last} = fifo_empty ? 13'd0 : head;

endmodule

// File: tb/tb_sti_so_packer.sv
// Bench for sti_so_packer: directed bursts plus random traffic against a bit-queue reference model.
module tb_sti_so_packer;
    localparam int   DEPTH  = 4;
    localparam logic TB_PAD = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       so_data = 1'b0;
    logic       so_valid = 1'b0;
    logic [7:0] byte_data;
    logic [3:0] byte_nbits;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       overflow;
    logic [7:0] burst_cnt;

    sti_so_packer #(.FIFO_DEPTH(DEPTH), .PAD_BIT(TB_PAD)) dut (
        .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
        .byte_data(byte_data), .byte_nbits(byte_nbits), .byte_last(byte_last),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .overflow(overflow), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] n;
        logic       l;
    } ent_t;

    ent_t       exp_q[$];
    bit         m_bits[$];
    bit         m_prev_v;
    bit         m_held_v;
    logic [7:0] m_held;
    bit         m_tail_v;
    ent_t       m_tail;
    int         m_count;
    bit         m_ovf;
    logic [7:0] m_bursts;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_bits.delete();
        m_prev_v = 0;
        m_held_v = 0;
        m_held   = '0;
        m_tail_v = 0;
        m_tail   = '0;
        m_count  = 0;
        m_ovf    = 0;
        m_bursts = '0;
    endfunction

    function automatic void model_push(input ent_t e, input bit pop);
        if (m_count == DEPTH && !pop) begin
            m_ovf = 1;
        end else begin
            exp_q.push_back(e);
            m_count++;
        end
    endfunction

    // One clock edge of the reference: bytes are cut every 8 bits of a burst and appear one
    // edge after their 8th bit; a leftover partial byte appears one edge after the burst end.
    function automatic void model_step(input bit v, input bit d, input bit r);
        bit         pop;
        bit         bend;
        ent_t       e;
        logic [7:0] b;
        pop  = (m_count > 0) && r;
        bend = !v && m_prev_v;
        if (m_tail_v) begin
            model_push(m_tail, pop);
            m_tail_v = 0;
        end else if (m_held_v && (v || bend)) begin
            e.d = m_held;
            e.n = 4'd8;
            e.l = bend && (m_bits.size() == 0);
            model_push(e, pop);
            m_held_v = 0;
        end
        if (pop) m_count--;
        if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) b[7-i] = m_bits[i];
                m_held   = b;
                m_held_v = 1;
                m_bits.delete();
            end
        end else if (bend) begin
            m_bursts++;
            if (m_bits.size() != 0) begin
                for (int i = 0; i < 8; i++) b[7-i] = (i < m_bits.size()) ? m_bits[i] : TB_PAD;
                m_tail.d = b;
                m_tail.n = 4'(m_bits.size());
                m_tail.l = 1'b1;
                m_tail_v = 1;
                m_bits.delete();
            end
        end
        m_prev_v = v;
    endfunction

    always @(negedge clk) begin
        chk("byte_valid", 32'(byte_valid), 32'(m_count != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("burst_cnt", 32'(burst_cnt), 32'(m_bursts));
        if (byte_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'(byte_data), 32'hFFFF_FFFF);
            end else begin
                chk("byte_data", 32'(byte_data), 32'(exp_q[0].d));
                chk("byte_nbits", 32'(byte_nbits), 32'(exp_q[0].n));
                chk("byte_last", 32'(byte_last), 32'(exp_q[0].l));
                if (byte_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input bit v, input bit d, input bit r);
        so_valid   = v;
        so_data    = d;
        byte_ready = r;
        @(posedge clk);
        if (!reset) model_step(v, d, r);
        #1;
    endtask

    task automatic send(input logic [63:0] bits, input int n, input int gap, input bit r);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], r);
        for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, r);
    endtask

    task automatic do_reset();
        so_valid = 1'b0;
        so_data  = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_data", 32'(byte_data), 32'd0);
        chk("rst_byte_nbits", 32'(byte_nbits), 32'd0);
        chk("rst_byte_last", 32'(byte_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        send(64'hA5C3, 16, 4, 1'b1);
        send(64'hB6D, 12, 5, 1'b1);
        send(64'h5, 3, 4, 1'b1);

        send(64'h11_2233_4455, 40, 6, 1'b0);
        idle(8, 1'b1);

        for (int i = 4; i >= 0; i--) cycle(1'b1, 5'b10110 >> i, 1'b1);
        do_reset();
        send(64'h3C, 8, 4, 1'b1);

        send(64'hF0, 8, 1, 1'b1);
        send(64'h13, 5, 1, 1'b1);
        send(64'h0F, 8, 5, 1'b1);

        do_reset();
        for (int k = 0; k < 60; k++) begin
            int n;
            int gap;
            n   = int'($urandom_range(1, 24));
            gap = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) cycle(1'b1, 1'($urandom), $urandom_range(0, 3) != 0);
            for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, $urandom_range(0, 3) != 0);
        end
        idle(12, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
